load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits directly upstream of the data memory port, between the execute stage and the byte-lane memory bus.
- Accepts one load/store request at a time from the pipeline and translates it into word-aligned bus beats with a byte-lane mask.
- Splits accesses that cross a word boundary into two beats, then reassembles and sign/zero-extends load data.
- Holds the pipeline with a ready/valid stall until the response is returned.

Parameters:
- ALLOW_MISALIGNED, 1, 1 = split word-crossing accesses into two beats; 0 = flag them as errors with no bus access.
- XLEN, 32, data and address width; only 32 is supported.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when valid && ready.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I load/store funct3.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- mem_read  out  1  read beat active.
- mem_write  out  1  write beat active.
- mem_addr  out  32  word-aligned beat address.
- mem_byte_en  out  4  lane mask for the beat.
- mem_wdata  out  32  lane-shifted store data.
- mem_rdata  in  32  raw word returned by memory.
- mem_ready  in  1  beat completes this cycle.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load result; 0 for stores and errors.
- resp_err  out  1  illegal funct3 or disallowed misalignment.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset state: all outputs 0, state IDLE. req_ready is 0 while rst_n is low. Reset asserted mid-access abandons the access; no response is produced.
- States: IDLE, BEAT0, BEAT1, RESP.
- IDLE:
  - req_ready = 1.
  - On accept, latch we, funct3, addr and wdata.
  - Legal funct3 values:
    - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
    - Stores: 000 SB, 001 SH, 010 SW.
    - Any other value goes to RESP with resp_err=1.
  - Size n = 1, 2 or 4; off = addr[1:0].
  - lanes8 = ((1<<n)-1) << off, 8 bits wide.
  - If lanes8[7:4] != 0 and ALLOW_MISALIGNED=0, go to RESP with err=1. Otherwise go to BEAT0.
- BEAT0:
  - mem_addr = {addr[31:2],2'b00}; mem_byte_en = lanes8[3:0].
  - mem_wdata = low half of (wdata << 8*off), taken from a 64-bit shift.
  - mem_read = !we; mem_write = we.
  - Outputs are registered and held stable until mem_ready=1.
  - On mem_ready, capture mem_rdata into buf[31:0]. Go to BEAT1 if lanes8[7:4] != 0, else RESP.
- BEAT1:
  - mem_addr = previous beat address + 4, wrapping modulo 2^32.
  - mem_byte_en = lanes8[7:4]; mem_wdata = upper half of the shifted store data.
  - On mem_ready, capture mem_rdata into buf[63:32], then go to RESP.
- RESP:
  - mem_read and mem_write deassert on entry.
  - resp_valid = 1 for exactly one cycle.
  - For loads, resp_rdata = extend((buf >> 8*off)[8n-1:0]): sign-extend for LB/LH, zero-extend for LBU/LHU.
  - Return to IDLE.
- Latency with mem_ready tied to 1:
  - Aligned access: accept in cycle N, beat in N+1, resp_valid in N+2.
  - Split access: resp_valid in N+3.
  - Error: resp_valid in N+1.
- req_valid arriving while not in IDLE is ignored (req_ready=0). Back-to-back requests can be accepted at the earliest in the cycle after RESP.
- mem_ready sampled outside BEAT0/BEAT1 is ignored.
- resp_rdata and resp_err are held until the next RESP; only resp_valid qualifies them.

Decomposition:
- Shared package lsu_pkg:
  - funct3 localparams F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - State enum lsu_state_t.
  - Function size_of(funct3).
- One combinational sub-module, load_align_extend: inputs buf[63:0], off and funct3; output is the 32-bit extended result.

Test Plan:
- LW at 0x10010008, mem_ready=1, mem_rdata=0xDEADBEEF -> single beat, addr 0x10010008, byte_en 1111, resp_rdata 0xDEADBEEF at N+2.
- LB at 0x10010003, rdata=0x80FFFFFF -> byte_en 1000, resp 0xFFFFFF80. The same access as LBU -> resp 0x00000080.
- SH of 0x0000ABCD at 0x10010003:
  - Beat0: addr 0x10010000, byte_en 1000, wdata[31:24]=0xCD.
  - Beat1: addr 0x10010004, byte_en 0001, wdata[7:0]=0xAB.
  - resp_valid at N+3.
- LW at 0x00000006 with beat0 rdata=0x1122xxxx and beat1 rdata=0xxxxx3344 -> resp 0x33441122. mem_ready held low for 3 cycles on beat0 -> outputs stable throughout, resp delayed by 3.
- With ALLOW_MISALIGNED=0, LW at 0x2 -> no mem_read, resp_err=1 at N+1. funct3=011 -> resp_err=1.
- rst_n pulsed low during BEAT1 -> all outputs 0 immediately, no resp_valid, req_ready=1 after release.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   F3_*        : RV32I load/store funct3 encodings
//   lsu_state_t : access sequencer states
//   size_of     : access size in bytes for a funct3 (0 = not a size encoding)
//   f3_legal    : funct3 legality for a load or a store
//   lanes_of    : 8-bit lane mask across two adjacent words for a funct3/offset
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2,
    RESP  = 2'd3
  } lsu_state_t;

  function automatic logic [2:0] size_of(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: size_of = 3'd1;
      F3_H, F3_HU: size_of = 3'd2;
      F3_W:        size_of = 3'd4;
      default:     size_of = 3'd0;
    endcase
  endfunction

  // Stores have no unsigned variants, so only B/H/W are legal for them.
  function automatic logic f3_legal(input logic we, input logic [2:0] funct3);
    if (we) f3_legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    else    f3_legal = (size_of(funct3) != 3'd0);
  endfunction

  // Bits [3:0] are lanes of the addressed word, bits [7:4] spill into the next.
  function automatic logic [7:0] lanes_of(input logic [2:0] funct3, input logic [1:0] off);
    logic [7:0] base;
    case (size_of(funct3))
      3'd1:    base = 8'h01;
      3'd2:    base = 8'h03;
      3'd4:    base = 8'h0F;
      default: base = 8'h00;
    endcase
    lanes_of = base << off;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Bus bundle for the load/store unit: pipeline request, memory beat port and
// pipeline response.
//   slave  : the load/store unit's view (takes requests, drives memory beats)
//   master : the environment's view (issues requests, answers memory beats)
interface load_store_unit_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [3:0]  mem_byte_en;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  mem_rdata, mem_ready,
    output req_ready,
    output mem_read, mem_write, mem_addr, mem_byte_en, mem_wdata,
    output resp_valid, resp_rdata, resp_err
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    output mem_rdata, mem_ready,
    input  req_ready,
    input  mem_read, mem_write, mem_addr, mem_byte_en, mem_wdata,
    input  resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/load_align_extend.sv
// Load data alignment and extension (combinational).
//   buf_data : two captured memory words, {second beat, first beat}
//   off      : byte offset of the access within the first word
//   funct3   : load type; selects width and sign/zero extension
//   result   : right-aligned, extended load value (0 for non-load encodings)
module load_align_extend
  import lsu_pkg::*;
(
  input  logic [63:0] buf_data,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  function automatic logic signed [31:0] sext8(input logic signed [7:0] v);
    logic signed [31:0] r;
    r = v;
    return r;
  endfunction

  function automatic logic signed [31:0] sext16(input logic signed [15:0] v);
    logic signed [31:0] r;
    r = v;
    return r;
  endfunction

  // Only the low word of the shifted pair can hold the requested bytes.
  logic [31:0] sh;
  assign sh = 32'(buf_data >> {off, 3'b000});

  always_comb begin
    result = '0;
    case (funct3)
      F3_B:    result = sext8(sh[7:0]);
      F3_H:    result = sext16(sh[15:0]);
      F3_W:    result = sh;
      F3_BU:   result = {24'b0, sh[7:0]};
      F3_HU:   result = {16'b0, sh[15:0]};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the execute stage and a byte-lane memory bus.
// Takes one request at a time, issues one or two word-aligned beats with lane
// masks, and returns a one-cycle response carrying extended load data.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : request / memory beat / response bundle (slave view)
// Parameters:
//   ALLOW_MISALIGNED : 1 = split word-crossing accesses, 0 = reject them
//   XLEN             : data/address width (32 only)
module load_store_unit
  import lsu_pkg::*;
#(
  parameter bit ALLOW_MISALIGNED = 1'b1,
  parameter int XLEN             = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  load_store_unit_if.slave bus
);

  lsu_state_t state_q, state_d;

  // Latched request fields (data path, no reset needed).
  logic            we_q;
  logic [2:0]      f3_q;
  logic [1:0]      off_q;
  logic [7:0]      lanes_q;
  logic [XLEN-1:0] wdata_hi_q;
  logic [XLEN-1:0] buf_lo_q;
  logic [XLEN-1:0] buf_hi_q;

  // Registered outputs.
  logic            mem_read_q,   mem_read_d;
  logic            mem_write_q,  mem_write_d;
  logic [XLEN-1:0] mem_addr_q,   mem_addr_d;
  logic [3:0]      mem_be_q,     mem_be_d;
  logic [XLEN-1:0] mem_wdata_q,  mem_wdata_d;
  logic            resp_valid_q, resp_valid_d;
  logic [XLEN-1:0] resp_rdata_q, resp_rdata_d;
  logic            resp_err_q,   resp_err_d;

  // Request decode.
  logic              accept;
  logic [7:0]        req_lanes;
  logic              req_split;
  logic              req_legal;
  logic [2*XLEN-1:0] req_wsh;

  assign accept    = (state_q == IDLE) && bus.req_valid;
  assign req_lanes = lanes_of(bus.req_funct3, bus.req_addr[1:0]);
  assign req_split = |req_lanes[7:4];
  assign req_legal = f3_legal(bus.req_we, bus.req_funct3);
  assign req_wsh   = {{XLEN{1'b0}}, bus.req_wdata} << {bus.req_addr[1:0], 3'b000};

  // Load data: the word arriving this cycle is combined with the one already
  // captured so the result is ready on the same edge the last beat completes.
  logic [2*XLEN-1:0] align_in;
  logic [XLEN-1:0]   align_out;

  assign align_in = (state_q == BEAT1) ? {bus.mem_rdata, buf_lo_q}
                                       : {buf_hi_q, bus.mem_rdata};

  load_align_extend u_align (
    .buf_data (align_in),
    .off      (off_q),
    .funct3   (f3_q),
    .result   (align_out)
  );

  always_comb begin
    state_d      = state_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_be_d     = mem_be_q;
    mem_wdata_d  = mem_wdata_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (!req_legal || (req_split && !ALLOW_MISALIGNED)) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end else begin
            state_d     = BEAT0;
            mem_read_d  = !bus.req_we;
            mem_write_d = bus.req_we;
            mem_addr_d  = {bus.req_addr[XLEN-1:2], 2'b00};
            mem_be_d    = req_lanes[3:0];
            mem_wdata_d = req_wsh[XLEN-1:0];
          end
        end
      end

      BEAT0: begin
        if (bus.mem_ready) begin
          if (|lanes_q[7:4]) begin
            state_d     = BEAT1;
            mem_addr_d  = mem_addr_q + 32'd4;
            mem_be_d    = lanes_q[7:4];
            mem_wdata_d = wdata_hi_q;
          end else begin
            state_d      = RESP;
            mem_read_d   = 1'b0;
            mem_write_d  = 1'b0;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b0;
            resp_rdata_d = we_q ? '0 : align_out;
          end
        end
      end

      BEAT1: begin
        if (bus.mem_ready) begin
          state_d      = RESP;
          mem_read_d   = 1'b0;
          mem_write_d  = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_rdata_d = we_q ? '0 : align_out;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_be_q     <= '0;
      mem_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_be_q     <= mem_be_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      we_q       <= bus.req_we;
      f3_q       <= bus.req_funct3;
      off_q      <= bus.req_addr[1:0];
      lanes_q    <= req_lanes;
      wdata_hi_q <= req_wsh[2*XLEN-1:XLEN];
    end
    if ((state_q == BEAT0) && bus.mem_ready) buf_lo_q <= bus.mem_rdata;
    if ((state_q == BEAT1) && bus.mem_ready) buf_hi_q <= bus.mem_rdata;
  end

  // Ready is forced low while reset is held, even though state is IDLE.
  assign bus.req_ready   = rst_n && (state_q == IDLE);
  assign bus.mem_read    = mem_read_q;
  assign bus.mem_write   = mem_write_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_byte_en = mem_be_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_rdata  = resp_rdata_q;
  assign bus.resp_err    = resp_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit: one instance with misaligned
// splitting enabled (a) and one with it disabled (b).
module tb_load_store_unit;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  load_store_unit_if a ();
  load_store_unit_if b ();

  load_store_unit #(.ALLOW_MISALIGNED(1'b1), .XLEN(32)) u_lsu_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (a)
  );

  load_store_unit #(.ALLOW_MISALIGNED(1'b0), .XLEN(32)) u_lsu_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request on instance a for one cycle; returns in cycle N+1.
  task automatic issue_a(input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd);
    a.req_valid  = 1'b1;
    a.req_we     = we;
    a.req_funct3 = f3;
    a.req_addr   = addr;
    a.req_wdata  = wd;
    chk("a.req_ready", {31'b0, a.req_ready}, 32'd1);
    step();
    a.req_valid  = 1'b0;
  endtask

  task automatic issue_b(input logic [2:0] f3, input logic [31:0] addr);
    b.req_valid  = 1'b1;
    b.req_we     = 1'b0;
    b.req_funct3 = f3;
    b.req_addr   = addr;
    b.req_wdata  = '0;
    chk("b.req_ready", {31'b0, b.req_ready}, 32'd1);
    step();
    b.req_valid  = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, ".mem_read"},   {31'b0, a.mem_read},   32'd0);
    chk({tag, ".mem_write"},  {31'b0, a.mem_write},  32'd0);
    chk({tag, ".mem_addr"},   a.mem_addr,            32'd0);
    chk({tag, ".byte_en"},    {28'b0, a.mem_byte_en}, 32'd0);
    chk({tag, ".mem_wdata"},  a.mem_wdata,           32'd0);
    chk({tag, ".resp_valid"}, {31'b0, a.resp_valid}, 32'd0);
    chk({tag, ".resp_rdata"}, a.resp_rdata,          32'd0);
    chk({tag, ".resp_err"},   {31'b0, a.resp_err},   32'd0);
    chk({tag, ".req_ready"},  {31'b0, a.req_ready},  32'd0);
  endtask

  initial begin
    a.req_valid = 0; a.req_we = 0; a.req_funct3 = 0; a.req_addr = 0; a.req_wdata = 0;
    a.mem_rdata = 0; a.mem_ready = 0;
    b.req_valid = 0; b.req_we = 0; b.req_funct3 = 0; b.req_addr = 0; b.req_wdata = 0;
    b.mem_rdata = 0; b.mem_ready = 0;
    rst_n = 1'b0;

    // Reset state
    #1;
    chk_idle_outputs("rst");
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("rst.ready_after", {31'b0, a.req_ready}, 32'd1);

    // LW aligned
    a.mem_ready = 1'b1;
    a.mem_rdata = 32'hDEADBEEF;
    issue_a(1'b0, F3_W, 32'h10010008, 32'h0);
    chk("lw.mem_read",  {31'b0, a.mem_read}, 32'd1);
    chk("lw.mem_write", {31'b0, a.mem_write}, 32'd0);
    chk("lw.addr",      a.mem_addr, 32'h10010008);
    chk("lw.be",        {28'b0, a.mem_byte_en}, 32'hF);
    chk("lw.ready_busy", {31'b0, a.req_ready}, 32'd0);
    chk("lw.no_resp",   {31'b0, a.resp_valid}, 32'd0);
    step();
    chk("lw.resp_valid", {31'b0, a.resp_valid}, 32'd1);
    chk("lw.rdata",      a.resp_rdata, 32'hDEADBEEF);
    chk("lw.err",        {31'b0, a.resp_err}, 32'd0);
    chk("lw.read_off",   {31'b0, a.mem_read}, 32'd0);
    step();
    chk("lw.pulse_end",  {31'b0, a.resp_valid}, 32'd0);
    chk("lw.ready_back", {31'b0, a.req_ready}, 32'd1);
    chk("lw.rdata_hold", a.resp_rdata, 32'hDEADBEEF);

    // LB / LBU at byte 3
    a.mem_rdata = 32'h80FFFFFF;
    issue_a(1'b0, F3_B, 32'h10010003, 32'h0);
    chk("lb.addr", a.mem_addr, 32'h10010000);
    chk("lb.be",   {28'b0, a.mem_byte_en}, 32'h8);
    step();
    chk("lb.resp_valid", {31'b0, a.resp_valid}, 32'd1);
    chk("lb.rdata",      a.resp_rdata, 32'hFFFFFF80);
    step();
    issue_a(1'b0, F3_BU, 32'h10010003, 32'h0);
    step();
    chk("lbu.resp_valid", {31'b0, a.resp_valid}, 32'd1);
    chk("lbu.rdata",      a.resp_rdata, 32'h00000080);
    step();

    // Illegal funct3: load 011 and store 100
    issue_a(1'b0, 3'b011, 32'h10010000, 32'h0);
    chk("f3ld.resp_valid", {31'b0, a.resp_valid}, 32'd1);
    chk("f3ld.err",        {31'b0, a.resp_err}, 32'd1);
    chk("f3ld.rdata",      a.resp_rdata, 32'd0);
    chk("f3ld.no_read",    {31'b0, a.mem_read}, 32'd0);
    step();
    issue_a(1'b1, 3'b100, 32'h10010000, 32'h12345678);
    chk("f3st.err",      {31'b0, a.resp_err}, 32'd1);
    chk("f3st.no_write", {31'b0, a.mem_write}, 32'd0);
    step();

    // SH crossing a word boundary
    issue_a(1'b1, F3_H, 32'h10010003, 32'h0000ABCD);
    chk("sh.b0.write", {31'b0, a.mem_write}, 32'd1);
    chk("sh.b0.read",  {31'b0, a.mem_read}, 32'd0);
    chk("sh.b0.addr",  a.mem_addr, 32'h10010000);
    chk("sh.b0.be",    {28'b0, a.mem_byte_en}, 32'h8);
    chk("sh.b0.wdata", a.mem_wdata, 32'hCD000000);
    step();
    chk("sh.b1.addr",  a.mem_addr, 32'h10010004);
    chk("sh.b1.be",    {28'b0, a.mem_byte_en}, 32'h1);
    chk("sh.b1.wdata", a.mem_wdata, 32'h000000AB);
    chk("sh.b1.no_resp", {31'b0, a.resp_valid}, 32'd0);
    step();
    chk("sh.resp_valid", {31'b0, a.resp_valid}, 32'd1);
    chk("sh.rdata",      a.resp_rdata, 32'd0);
    chk("sh.err",        {31'b0, a.resp_err}, 32'd0);
    chk("sh.write_off",  {31'b0, a.mem_write}, 32'd0);
    step();

    // Split LW with three stall cycles on the first beat
    a.mem_ready = 1'b0;
    a.mem_rdata = 32'h0BADF00D;
    issue_a(1'b0, F3_W, 32'h00000006, 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk("lwx.stall.addr", a.mem_addr, 32'h00000004);
      chk("lwx.stall.be",   {28'b0, a.mem_byte_en}, 32'hC);
      chk("lwx.stall.read", {31'b0, a.mem_read}, 32'd1);
      chk("lwx.stall.resp", {31'b0, a.resp_valid}, 32'd0);
      step();
    end
    chk("lwx.b0.addr", a.mem_addr, 32'h00000004);
    a.mem_ready = 1'b1;
    a.mem_rdata = 32'h11225566;
    step();
    chk("lwx.b1.addr", a.mem_addr, 32'h00000008);
    chk("lwx.b1.be",   {28'b0, a.mem_byte_en}, 32'h3);
    chk("lwx.b1.read", {31'b0, a.mem_read}, 32'd1);
    chk("lwx.b1.resp", {31'b0, a.resp_valid}, 32'd0);
    a.mem_rdata = 32'h77883344;
    step();
    chk("lwx.resp_valid", {31'b0, a.resp_valid}, 32'd1);
    chk("lwx.rdata",      a.resp_rdata, 32'h33441122);
    step();
    chk("lwx.pulse_end",  {31'b0, a.resp_valid}, 32'd0);

    // Misalignment disabled: LW at 0x2 rejected, LH at 0x2 allowed
    b.mem_ready = 1'b1;
    b.mem_rdata = 32'hBEEF0000;
    issue_b(F3_W, 32'h00000002);
    chk("nomis.resp_valid", {31'b0, b.resp_valid}, 32'd1);
    chk("nomis.err",        {31'b0, b.resp_err}, 32'd1);
    chk("nomis.no_read",    {31'b0, b.mem_read}, 32'd0);
    step();
    issue_b(F3_H, 32'h00000002);
    chk("nomis.lh.read", {31'b0, b.mem_read}, 32'd1);
    chk("nomis.lh.be",   {28'b0, b.mem_byte_en}, 32'hC);
    step();
    chk("nomis.lh.resp_valid", {31'b0, b.resp_valid}, 32'd1);
    chk("nomis.lh.rdata",      b.resp_rdata, 32'hFFFFBEEF);
    chk("nomis.lh.err",        {31'b0, b.resp_err}, 32'd0);
    step();

    // Reset in the middle of the second beat
    a.mem_ready = 1'b1;
    issue_a(1'b0, F3_W, 32'h00000006, 32'h0);
    step();
    chk("rstm.b1.be", {28'b0, a.mem_byte_en}, 32'h3);
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("rstm");
    step();
    chk("rstm.held.resp", {31'b0, a.resp_valid}, 32'd0);
    #2;
    rst_n = 1'b1;
    #1;
    chk("rstm.ready_rel", {31'b0, a.req_ready}, 32'd1);
    a.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rstm.no_resp", {31'b0, a.resp_valid}, 32'd0);
      chk("rstm.no_read", {31'b0, a.mem_read}, 32'd0);
      chk("rstm.ready",   {31'b0, a.req_ready}, 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
